// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Brief    : Two-requester round-robin arbiter for a shared data-memory port
//            (IDLE -> ACCESS -> RESP). Optional ARB_WRITE_PROTECT_EN blocks m1
//            writes to 0x6000..0x10000 and flags them on wr_err.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    output logic              m0_gnt,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m1_gnt,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              wr_err
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_access = 2'd1;
    localparam logic [1:0] c_resp   = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_m1;
    logic              r_sel_m1;
    logic              r_prot;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_err;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wd;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_any;
    logic              w_pick_m1;
    logic              w_prot;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_wd;
    logic              w_win_we;

    // On a tie the requester that was not served last wins.
    assign w_any      = m0_req | m1_req;
    assign w_pick_m1  = m1_req & (~m0_req | ~r_last_m1);
    assign w_win_addr = w_pick_m1 ? m1_addr : m0_addr;
    assign w_win_wd   = w_pick_m1 ? m1_wd   : m0_wd;
    assign w_win_we   = w_pick_m1 ? m1_we   : m0_we;

`ifdef ARB_WRITE_PROTECT_EN
    localparam logic [ADDR_W-1:0] c_prot_lo = ADDR_W'(32'h0000_6000);
    localparam logic [ADDR_W-1:0] c_prot_hi = ADDR_W'(32'h0001_0000);
    assign w_prot = w_pick_m1 & m1_we & (m1_addr >= c_prot_lo) & (m1_addr <= c_prot_hi);
`else
    assign w_prot = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_idle;
            r_last_m1  <= 1'b1;
            r_sel_m1   <= 1'b0;
            r_prot     <= 1'b0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_mem_we   <= 1'b0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_any) begin
                        r_state    <= c_access;
                        r_busy     <= 1'b1;
                        r_sel_m1   <= w_pick_m1;
                        r_last_m1  <= w_pick_m1;
                        r_prot     <= w_prot;
                        r_mem_addr <= w_win_addr;
                        r_mem_wd   <= w_win_wd;
                        r_mem_we   <= w_win_we & ~w_prot;
                    end
                end
                c_access: begin
                    r_state    <= c_resp;
                    r_mem_addr <= '0;
                    r_mem_wd   <= '0;
                    r_mem_we   <= 1'b0;
                    if (r_sel_m1) r_rdata1 <= mem_rd;
                    else          r_rdata0 <= mem_rd;
                    r_gnt0     <= ~r_sel_m1;
                    r_gnt1     <= r_sel_m1;
                    r_err      <= r_prot;
                end
                c_resp: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state    <= c_idle;
                    r_busy     <= 1'b0;
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_err      <= 1'b0;
                    r_mem_addr <= '0;
                    r_mem_wd   <= '0;
                    r_mem_we   <= 1'b0;
                end
            endcase
        end
    end

    // Reset in the RESP cycle must suppress the grant that is already registered.
    assign m0_gnt   = r_gnt0 & ~reset;
    assign m1_gnt   = r_gnt1 & ~reset;
    assign wr_err   = r_err & ~reset;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign mem_we   = r_mem_we;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Brief    : Scoreboard bench for data_bus_arbiter; expected grants and memory
//            writes are queued by the stimulus and consumed by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic        m0_gnt, m1_gnt;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we, busy, wr_err;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        bit          chk_rd;
        bit          err;
    } gnt_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    gnt_t gq[$];
    wr_t  wq[$];
    gnt_t e;
    wr_t  w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_gnt = -1;
    bit gap_en   = 0;
    bit mon_en   = 0;

`ifdef ARB_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    data_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
        .busy(busy), .wr_err(wr_err)
    );

    // Memory read model: 0x6000 holds 3, everything else reads addr ^ 0x5A5A0000.
    assign mem_rd = (mem_addr == 32'h0000_6000) ? 32'h0000_0003 : (mem_addr ^ 32'h5A5A_0000);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Requester: hold request until grant, then drop (or keep for back-to-back).
    task automatic xfer(input int m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit keep);
        bit got;
        got = 0;
        if (m == 0) begin m0_we = we; m0_addr = addr; m0_wd = wd; m0_req = 1'b1; end
        else        begin m1_we = we; m1_addr = addr; m1_wd = wd; m1_req = 1'b1; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_gnt) || (m == 1 && m1_gnt)) got = 1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout actual=no_gnt required=gnt master=%0d addr=0x%0h", m, addr);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            if (m == 0) m0_req = 1'b0;
            else        m1_req = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (m0_gnt || m1_gnt) begin
                check("gnt_onehot", {63'b0, m0_gnt & m1_gnt}, 64'd0);
                if (gq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_gnt actual m0_gnt=%0b m1_gnt=%0b required=none", m0_gnt, m1_gnt);
                end else begin
                    e = gq.pop_front();
                    check("gnt_id", {63'b0, m1_gnt}, 64'(e.id));
                    if (e.chk_rd) check("rdata", 64'(e.id == 1 ? m1_rdata : m0_rdata), 64'(e.rdata));
                    check("wr_err", {63'b0, wr_err}, {63'b0, e.err});
                    check("resp_we", {63'b0, mem_we}, 64'd0);
                    if (gap_en && last_gnt >= 0) check("gnt_gap", 64'(cyc - last_gnt), 64'd3);
                    last_gnt = cyc;
                end
            end else begin
                check("err_idle", {63'b0, wr_err}, 64'd0);
            end
            if (mem_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_we actual addr=0x%0h data=0x%0h required=no_write", mem_addr, mem_wd);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(w.addr));
                    check("wr_data", 64'(mem_wd), 64'(w.data));
                end
            end else if (!busy) begin
                check("idle_bus", 64'(mem_addr | mem_wd), 64'd0);
            end
        end
    end

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] data;
        bit          prot;
    } pw_t;
    pw_t ptab[6];

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {59'b0, m0_gnt, m1_gnt, mem_we, busy, wr_err}, 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wd", 64'(mem_wd), 64'd0);
        check("rst_rdata0", 64'(m0_rdata), 64'd0);
        check("rst_rdata1", 64'(m1_rdata), 64'd0);
        mon_en = 1;
        sync();

        // Single m0 read with latency probes
        gq.push_back('{0, 32'h0000_0003, 1'b1, 1'b0});
        fork
            xfer(0, 1'b0, 32'h0000_6000, 32'h0, 1'b0);
            begin
                @(negedge clk); check("lat_idle_busy", {63'b0, busy}, 64'd0);
                @(negedge clk); check("lat_mem_addr", 64'(mem_addr), 64'h6000);
                                check("lat_busy", {63'b0, busy}, 64'd1);
                @(negedge clk); check("lat_gnt", {63'b0, m0_gnt}, 64'd1);
            end
        join
        sync();

        // m1 read; m0_rdata must hold
        gq.push_back('{1, 32'h5A5A_2000, 1'b1, 1'b0});
        xfer(1, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
        check("rdata0_hold", 64'(m0_rdata), 64'h3);

        // Fresh reset, simultaneous writes: m0 first
        reset = 1'b1; sync(); reset = 1'b0;
        gq.push_back('{0, 32'h0, 1'b0, 1'b0});
        gq.push_back('{1, 32'h0, 1'b0, 1'b0});
        wq.push_back('{32'h100, 32'h1111_1111});
        wq.push_back('{32'h200, 32'h2222_2222});
        fork
            xfer(0, 1'b1, 32'h100, 32'h1111_1111, 1'b0);
            xfer(1, 1'b1, 32'h200, 32'h2222_2222, 1'b0);
        join
        sync();

        // Continuous requesting: strict alternation, 3-cycle spacing
        gap_en = 1; last_gnt = -1;
        gq.push_back('{0, 32'h5A5A_0010, 1'b1, 1'b0});
        gq.push_back('{1, 32'h5A5A_0020, 1'b1, 1'b0});
        gq.push_back('{0, 32'h5A5A_0014, 1'b1, 1'b0});
        gq.push_back('{1, 32'h5A5A_0024, 1'b1, 1'b0});
        gq.push_back('{0, 32'h5A5A_0018, 1'b1, 1'b0});
        gq.push_back('{1, 32'h5A5A_0028, 1'b1, 1'b0});
        fork
            for (int i = 0; i < 3; i++) xfer(0, 1'b0, 32'h10 + 32'(4*i), 32'h0, i < 2);
            for (int j = 0; j < 3; j++) xfer(1, 1'b0, 32'h20 + 32'(4*j), 32'h0, j < 2);
        join
        gap_en = 0;
        sync();

        // Reset in RESP aborts the grant; the write already happened; retry completes
        wq.push_back('{32'h300, 32'h3333_3333});
        wq.push_back('{32'h300, 32'h3333_3333});
        gq.push_back('{0, 32'h0, 1'b0, 1'b0});
        fork
            xfer(0, 1'b1, 32'h300, 32'h3333_3333, 1'b0);
            begin
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                @(negedge clk); check("abort_no_gnt", {62'b0, m0_gnt, m1_gnt}, 64'd0);
                @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                check("abort_ctrl", {59'b0, m0_gnt, m1_gnt, mem_we, busy, wr_err}, 64'd0);
                check("abort_bus", 64'(mem_addr | mem_wd), 64'd0);
                check("abort_rdata", 64'(m0_rdata | m1_rdata), 64'd0);
            end
        join
        sync();

        // Write-protect window boundaries (m0 never protected)
        ptab[0] = '{1, 32'h0000_7000, 32'h0000_0077, 1'b1};
        ptab[1] = '{1, 32'h0000_6000, 32'h0000_0060, 1'b1};
        ptab[2] = '{1, 32'h0001_0000, 32'h0000_0100, 1'b1};
        ptab[3] = '{1, 32'h0000_5FFC, 32'h0000_005F, 1'b0};
        ptab[4] = '{1, 32'h0001_0004, 32'h0000_0104, 1'b0};
        ptab[5] = '{0, 32'h0000_7000, 32'h0000_0070, 1'b0};
        for (int k = 0; k < 6; k++) begin
            gq.push_back('{ptab[k].m, 32'h0, 1'b0, ptab[k].prot & PROT_ON});
            if (!(ptab[k].prot & PROT_ON)) wq.push_back('{ptab[k].addr, ptab[k].data});
            xfer(ptab[k].m, 1'b1, ptab[k].addr, ptab[k].data, 1'b0);
        end
        sync();

        // m1 request raised and withdrawn while busy is never granted
        gq.push_back('{0, 32'h5A5A_0040, 1'b1, 1'b0});
        fork
            xfer(0, 1'b0, 32'h40, 32'h0, 1'b0);
            begin
                @(posedge clk);
                #1 m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
                @(posedge clk);
                #1 m1_req = 1'b0;
            end
        join
        repeat (5) sync();
        check("rdata1_hold", 64'(m1_rdata), 64'h5A5B_0004);

        repeat (3) sync();
        check("gq_empty", 64'(gq.size()), 64'd0);
        check("wq_empty", 64'(wq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
